mul_div_seq: RTL
================

Name: mul_div_seq

Overview:
- Parametrised iterative multiply/divide unit for the CPU datapath.
- Takes two WIDTH-bit operands from the bus side (the Y register and the bus value) and produces a 2*WIDTH-bit result, split into hi/lo words for loading into HI/LO.
- Replaces single-shot mul/div in the ALU with a start/busy/done multi-cycle sequencer.
- Supports signed/unsigned multiply and divide, divide-by-zero flagging and abort.

Parameters:
- WIDTH, 32, operand width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (localparam; not overridable).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  reset; asynchronous, active-low.
- start  in  1  request operation; sampled only in IDLE.
- abort  in  1  cancel the operation in progress; no done is produced.
- op  in  2  00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU.
- a_in  in  WIDTH  multiplicand / dividend; captured on the accepted start edge.
- b_in  in  WIDTH  multiplier / divisor; captured on the accepted start edge.
- busy  out  1  high from the edge after start is accepted until the edge that raises done.
- done  out  1  single-cycle pulse; results valid from this cycle onward.
- hi_out  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- lo_out  out  WIDTH  MUL: product[W-1:0]; DIV: quotient.
- div_by_zero  out  1  set with done when a DIV/DIVU had b=0; cleared on the next accepted start.

Behaviour:
- Reset (clear=0, async): state IDLE; busy, done, div_by_zero, hi_out, lo_out, counter and internal operand registers all 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE: when start=1, capture op, a_in and b_in, and clear div_by_zero.
  - Signed ops: store the magnitudes plus a result-sign bit and a dividend-sign bit.
  - Next state is RUN, except DIV/DIVU with b=0, which goes to DONE.
- RUN, one iteration per cycle, WIDTH cycles, counter runs WIDTH-1 down to 0:
  - MUL: shift-add on magnitudes (add multiplicand to upper accumulator if the LSB of the multiplier is set, then shift right by 1).
  - DIV: restoring step (shift remainder:quotient left by 1, trial subtract the divisor, keep if non-negative and set the quotient bit).
  - Go to FIX when the counter reaches 0.
- FIX (1 cycle), applies sign correction:
  - MUL signed: negate the full 2W product if the result-sign bit is set.
  - DIV signed: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative (truncation toward zero; remainder takes the dividend's sign).
  - Load hi_out/lo_out, then go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start seen in DONE is ignored; it must be re-presented in IDLE.
- Latency, with the start accepted at edge k:
  - busy=1 from edge k+1.
  - Normal operation: done=1 in the cycle following edge k+WIDTH+2 (34 cycles for WIDTH=32).
  - Divide-by-zero: done at edge k+2 with hi_out=a_in, lo_out={WIDTH{1'b1}}, div_by_zero=1.
- Signed overflow, DIV MIN/-1: lo_out=MIN and hi_out=0 (the natural wrap); div_by_zero stays 0.
- start while busy: ignored; the operands in flight are unaffected.
- abort=1 in RUN or FIX: go to IDLE on the next edge with busy=0 and no done. hi_out, lo_out and div_by_zero keep their prior values. abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start wins, since abort has no effect in IDLE.
- Async reset mid-operation: immediate return to the reset values; no done pulse.
- hi_out/lo_out change only in FIX (or DONE on the divide-by-zero path); they hold until the next completed operation.

Decomposition:
- Shared package mul_div_pkg holds:
  - op encodings: OP_MUL=2'b00, OP_MULU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - state encoding: IDLE, RUN, FIX, DONE;
  - the datapath's 5-bit ALU opcode values that map onto these ops.
- Single module; the negate/abs logic is inline functions. No sub-module is warranted.

Test Plan:
- MUL, a=0xFFFFFFFE, b=3 -> done exactly 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for 33 cycles.
- MULU, same operands -> hi=0x00000002, lo=0xFFFFFFFA. MUL 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU 0x1234/0 -> done 2 cycles after start; hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1. The next valid start clears div_by_zero.
- Start MULU 5*6, then pulse start with other operands at cycle 10 -> ignored; result hi=0, lo=30. Pulse abort at cycle 15 of a following DIVU -> busy drops next cycle, no done, hi/lo still 0/30.
- Drive clear low at cycle 20 of a MUL -> all outputs 0 immediately. After release, a new MUL 3*4 -> lo=12, with normal latency.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// sequencer states and the datapath ALU opcodes that select each operation.
package mul_div_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // 5-bit ALU opcodes issued by the datapath decoder for HI/LO operations
  localparam logic [4:0] ALU_MUL  = 5'b11000;
  localparam logic [4:0] ALU_MULU = 5'b11001;
  localparam logic [4:0] ALU_DIV  = 5'b11010;
  localparam logic [4:0] ALU_DIVU = 5'b11011;

  // Translate a datapath ALU opcode into the unit's 2-bit operation code
  function automatic logic [1:0] alu_to_op(input logic [4:0] alu_op);
    logic [1:0] res;
    case (alu_op)
      ALU_MULU: res = OP_MULU;
      ALU_DIV:  res = OP_DIV;
      ALU_DIVU: res = OP_DIVU;
      default:  res = OP_MUL;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_div_seq.sv
// Iterative signed/unsigned multiply and divide with a start/busy/done
// handshake. Works on operand magnitudes for WIDTH cycles, then applies the
// sign correction in a single fix-up cycle before loading HI/LO.
module mul_div_seq
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return '0 - v;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               div_r;
  logic               res_neg;
  logic               dvd_neg;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               b_zero;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Split the incoming operands into magnitude and sign for signed ops
  always_comb begin
    a_neg  = ~op[0] & a_in[WIDTH-1];
    b_neg  = ~op[0] & b_in[WIDTH-1];
    a_mag  = a_neg ? neg_w(a_in) : a_in;
    b_mag  = b_neg ? neg_w(b_in) : b_in;
    b_zero = (b_in == '0);
  end

  // One shift-add or restoring-divide iteration on the working accumulator
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (div_r) begin
      step_acc = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign-corrected results; the sign flags are only ever set for signed ops
  always_comb begin
    prod_fix = res_neg ? neg_2w(acc) : acc;
    quo_fix  = res_neg ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = dvd_neg ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer: capture, iterate, fix up signs, then signal completion.
  // DONE is entered with busy low only on the divide-by-zero path, which
  // uses its first DONE cycle to load the fixed result and raise busy.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      cnt         <= '0;
      div_r       <= 1'b0;
      res_neg     <= 1'b0;
      dvd_neg     <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_r       <= op[1];
            res_neg     <= a_neg ^ b_neg;
            dvd_neg     <= a_neg;
            div_by_zero <= 1'b0;
            cnt         <= CNT_W'(WIDTH - 1);
            if (op[1] && b_zero) begin
              opnd  <= '0;
              acc   <= {{WIDTH{1'b0}}, a_in};
              state <= DONE;
            end else if (op[1]) begin
              opnd  <= b_mag;
              acc   <= {{WIDTH{1'b0}}, a_mag};
              state <= RUN;
            end else begin
              opnd  <= a_mag;
              acc   <= {{WIDTH{1'b0}}, b_mag};
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            busy <= 1'b1;
            acc  <= step_acc;
            if (cnt == '0) begin
              state <= FIX;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        FIX: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (div_r) begin
              hi_out <= rem_fix;
              lo_out <= quo_fix;
            end else begin
              hi_out <= prod_fix[2*WIDTH-1:WIDTH];
              lo_out <= prod_fix[WIDTH-1:0];
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (!busy) begin
            hi_out <= acc[WIDTH-1:0];
            lo_out <= '1;
            busy   <= 1'b1;
          end else begin
            done        <= 1'b1;
            busy        <= 1'b0;
            div_by_zero <= div_r && (opnd == '0);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
